cam_capture_win: RTL and testbench

CAM_CAPTURE_WIN -- requirements
Module: cam_capture_win

---
 rtl/cam_capture_win.sv | 140 ++++++++++++++
 tb/tb_cam_capture_win.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_win.sv
// Camera frame grabber: windowed, decimated pixel capture into a PIX_W-wide buffer.
// Latency: pixel written on its last byte, read data 1 cycle after rd_en; no backpressure (sensor-paced, excess dropped).
module cam_capture_win #(
  parameter int ADDR_W        = 12,
  parameter int PIX_W         = 4,
  parameter int BYTES_PER_PIX = 2,
  parameter int WIN_X0        = 0,
  parameter int WIN_W         = 64,
  parameter int WIN_Y0        = 0,
  parameter int WIN_H         = 64,
  parameter int DECIM         = 1
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        data,
  input  logic              arm,
  input  logic              continuous,
  input  logic              disarm,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic [ADDR_W:0]   wr_count
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [0:0] LAST_PH = 1'(BYTES_PER_PIX - 1);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

  state_t             state_q, state_d;
  logic               vs_q, href_q, disarm_lat;
  logic [0:0]         phase;
  logic [15:0]        x, y;
  logic [16:0]        xr, yr;
  logic [PIX_W-1:0]   first_q, pix_val;
  logic [PIX_W-1:0]   mem [DEPTH];
  logic               vs_rise, vs_fall, href_fall, pix_done, in_win, store, full;
  logic               unused_data;

  assign unused_data = ^data;

  assign vs_rise   = vsync & ~vs_q;
  assign vs_fall   = ~vsync & vs_q;
  assign href_fall = href_q & ~href;

  // Borrow out of the 17-bit subtraction means the coordinate is left of / above the window.
  assign xr     = {1'b0, x} - 17'(WIN_X0);
  assign yr     = {1'b0, y} - 17'(WIN_Y0);
  assign in_win = !xr[16] && (xr[15:0] < 16'(WIN_W)) && ((xr[15:0] % 16'(DECIM)) == 16'd0) &&
                  !yr[16] && (yr[15:0] < 16'(WIN_H)) && ((yr[15:0] % 16'(DECIM)) == 16'd0);

  assign pix_val  = (BYTES_PER_PIX == 1) ? data[7 -: PIX_W] : first_q;
  assign pix_done = (state_q == CAPTURE) && href && !vs_rise && (phase == LAST_PH);
  assign store    = pix_done && in_win;
  assign full     = wr_count[ADDR_W];

  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm)     state_d = WAIT_VS;
      WAIT_VS: if (vs_fall) state_d = CAPTURE;
      CAPTURE: if (vs_rise) state_d = DONE;
      DONE:    state_d = (continuous && !disarm_lat && !disarm) ? WAIT_VS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vs_q       <= 1'b0;
      href_q     <= 1'b0;
      disarm_lat <= 1'b0;
      phase      <= '0;
      x          <= '0;
      y          <= '0;
      first_q    <= '0;
      wr_count   <= '0;
      overflow   <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_q    <= vsync;
      href_q  <= href;
      if (disarm && state_q != IDLE) disarm_lat <= 1'b1;
      case (state_q)
        IDLE: if (arm) begin
          wr_count   <= '0;
          overflow   <= 1'b0;
          disarm_lat <= 1'b0;
        end
        // Each captured frame refills the buffer from address 0; overflow stays sticky until arm.
        WAIT_VS: if (vs_fall) begin
          x        <= '0;
          y        <= '0;
          phase    <= '0;
          wr_count <= '0;
        end
        CAPTURE: if (!vs_rise) begin
          if (href) begin
            if (phase == LAST_PH) begin
              phase <= '0;
              x     <= (x == 16'hFFFF) ? x : x + 16'd1;
            end else begin
              phase   <= phase + 1'b1;
              first_q <= data[7 -: PIX_W];
            end
          end else if (href_fall) begin
            x     <= '0;
            phase <= '0;
            y     <= (y == 16'hFFFF) ? y : y + 16'd1;
          end
          if (store) begin
            if (full) overflow <= 1'b1;
            else      wr_count <= wr_count + (ADDR_W+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (store && !full) mem[wr_count[ADDR_W-1:0]] <= pix_val;
  end

  // Non-blocking read of the same array gives read-before-write on an address collision.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_cam_capture_win.sv
// Randomised frame stimulus against a window/decimation reference model; scoreboard queues
// are filled by the stimulus and drained by a monitor on frame_done and read-data events.
module tb_cam_capture_win;

  localparam int AW = 4, PW = 4, DEPTH = 16;
  localparam int WX0 = 2, WW = 10, WY0 = 1, WH = 7, DEC = 2;

  logic          pclk, rst_n, vsync, href, arm, continuous, disarm, rd_en;
  logic [7:0]    data;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_data;
  logic          busy, frame_done, overflow;
  logic [AW:0]   wr_count;

  cam_capture_win #(
    .ADDR_W(AW), .PIX_W(PW), .BYTES_PER_PIX(2), .WIN_X0(WX0), .WIN_W(WW),
    .WIN_Y0(WY0), .WIN_H(WH), .DECIM(DEC)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .data(data),
    .arm(arm), .continuous(continuous), .disarm(disarm), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .frame_done(frame_done),
    .overflow(overflow), .wr_count(wr_count)
  );

  typedef struct { logic [PW-1:0] v; bit k; } rd_exp_t;
  typedef struct { int cnt; bit ovf; } fr_exp_t;

  rd_exp_t       exp_rd[$];
  fr_exp_t       exp_fr[$];
  logic [PW-1:0] mem_m [DEPTH];
  bit            known [DEPTH];
  bit            ovf_m;
  bit            rd_v;
  int            n_tests = 0, n_fail = 0;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  function automatic bit in_win(input int x, input int y);
    return (x >= WX0) && (x < WX0 + WW) && (y >= WY0) && (y < WY0 + WH) &&
           ((x - WX0) % DEC == 0) && ((y - WY0) % DEC == 0);
  endfunction

  always @(posedge pclk or negedge rst_n)
    if (!rst_n) rd_v <= 1'b0;
    else        rd_v <= rd_en;

  // Monitor: pops the scoreboard whenever the DUT presents read data or a frame_done pulse.
  always @(negedge pclk) begin
    rd_exp_t r;
    fr_exp_t f;
    if (rd_v) begin
      if (exp_rd.size() == 0) check("unexpected_read", 1, 0);
      else begin
        r = exp_rd.pop_front();
        if (r.k) check("rd_data", 32'(rd_data), 32'(r.v));
      end
    end
    if (frame_done) begin
      if (exp_fr.size() == 0) check("unexpected_frame_done", 1, 0);
      else begin
        f = exp_fr.pop_front();
        check("frame_wr_count", 32'(wr_count), 32'(f.cnt));
        check("frame_overflow", 32'(overflow), 32'(f.ovf));
      end
    end
  end

  task automatic rand_read();
    int a;
    rd_exp_t r;
    if ($urandom_range(3) == 0) begin
      a = $urandom_range(DEPTH - 1);
      rd_en = 1'b1; rd_addr = AW'(a);
      r.v = mem_m[a]; r.k = known[a];
      exp_rd.push_back(r);
    end else rd_en = 1'b0;
  endtask

  // mode 0: full frame; 1: vsync rises on the 2nd byte of pixel (cl,cp); 2: return after that pixel's 1st byte.
  task automatic send_frame(input int w, input int h, input bit cap, input int mode,
                            input int cl, input int cp, input bit dis_mid, input bit arm_mid);
    int n;
    bit stop;
    logic [7:0] b0, b1;
    rd_exp_t r;
    fr_exp_t f;
    n = 0; stop = 0;
    vsync = 1'b1; href = 1'b0; repeat (3) tick();
    vsync = 1'b0; repeat (2) tick();
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        b0 = 8'($urandom); b1 = 8'($urandom);
        href = 1'b1; data = b0; rand_read();
        if (y == 1 && x == 0) begin disarm = dis_mid; arm = arm_mid; end
        tick();
        disarm = 1'b0; arm = 1'b0;
        if (mode != 0 && y == cl && x == cp) begin stop = 1; break; end
        data = b1;
        if (cap && in_win(x, y)) begin
          if (n < DEPTH) begin
            rd_en = 1'b1; rd_addr = AW'(n);
            r.v = mem_m[n]; r.k = known[n];
            exp_rd.push_back(r);
            mem_m[n] = b0[7:4]; known[n] = (mode != 2);
          end else begin
            rd_en = 1'b0; ovf_m = 1;
          end
          n++;
        end else rand_read();
        tick();
        rd_en = 1'b0;
      end
      if (stop) break;
      href = 1'b0; repeat (3) tick();
    end
    if (mode == 2) return;
    if (cap) begin
      f.cnt = (n < DEPTH) ? n : DEPTH; f.ovf = ovf_m;
      exp_fr.push_back(f);
    end
    vsync = 1'b1;
    if (stop) data = 8'($urandom);
    rand_read();
    tick();
    href = 1'b0; rd_en = 1'b0;
    repeat (4) tick();
  endtask

  task automatic arm_cap(input bit c);
    continuous = c; arm = 1'b1; tick(); arm = 1'b0; ovf_m = 0;
    check("busy_after_arm", 32'(busy), 1);
    check("ovf_clr_on_arm", 32'(overflow), 0);
    check("cnt_clr_on_arm", 32'(wr_count), 0);
  endtask

  task automatic wait_frames();
    int t = 0;
    while (exp_fr.size() != 0 && t < 40) begin tick(); t++; end
    if (exp_fr.size() != 0) begin
      check("frame_done_timeout", 32'(exp_fr.size()), 0);
      exp_fr.delete();
    end
  endtask

  task automatic readback();
    rd_exp_t r;
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1'b1; rd_addr = AW'(a);
      r.v = mem_m[a]; r.k = known[a];
      exp_rd.push_back(r);
      tick();
    end
    rd_en = 1'b0;
    tick(); tick();
    if (known[DEPTH-1]) check("rd_hold", 32'(rd_data), 32'(mem_m[DEPTH-1]));
  endtask

  initial begin
    int w, h, md;
    rst_n = 1'b0; vsync = 1'b1; href = 1'b0; data = '0; arm = 1'b0;
    continuous = 1'b0; disarm = 1'b0; rd_en = 1'b0; rd_addr = '0; ovf_m = 0;
    for (int i = 0; i < DEPTH; i++) begin mem_m[i] = '0; known[i] = 0; end
    #2;
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_wr_count", 32'(wr_count), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    #10 rst_n = 1'b1;
    tick(); tick();

    // Full window with a 20-pixel selection into a 16-deep buffer.
    arm_cap(0);
    send_frame(14, 9, 1, 0, 0, 0, 0, 0);
    wait_frames();
    check("idle_after_single", 32'(busy), 0);
    readback();

    // Overflow from the previous frame must be cleared by this arm.
    arm_cap(0);
    send_frame(16, 4, 1, 0, 0, 0, 0, 0);
    wait_frames();
    readback();

    for (int it = 0; it < 6; it++) begin
      w = $urandom_range(1, 16); h = $urandom_range(1, 10); md = $urandom_range(0, 1);
      arm_cap(0);
      send_frame(w, h, 1, md, $urandom_range(h - 1), $urandom_range(w - 1), 0, 0);
      wait_frames();
      check("idle_after_rand", 32'(busy), 0);
      readback();
    end

    // Continuous: disarm and an ignored arm during frame 2, frame 3 not captured.
    arm_cap(1);
    send_frame(14, 9, 1, 0, 0, 0, 0, 0);
    send_frame(12, 6, 1, 0, 0, 0, 1, 1);
    send_frame(10, 5, 0, 0, 0, 0, 0, 0);
    wait_frames();
    check("idle_after_disarm", 32'(busy), 0);
    continuous = 1'b0;
    readback();

    // Asynchronous reset in the middle of a line.
    arm_cap(0);
    send_frame(14, 9, 1, 2, 3, 4, 0, 0);
    rd_en = 1'b0;
    tick();
    check("pre_reset_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_wr_count", 32'(wr_count), 0);
    check("async_rst_overflow", 32'(overflow), 0);
    check("async_rst_rd_data", 32'(rd_data), 0);
    href = 1'b0; vsync = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    send_frame(8, 4, 0, 0, 0, 0, 0, 0);
    check("no_arm_wr_count", 32'(wr_count), 0);
    check("no_arm_busy", 32'(busy), 0);

    arm_cap(0);
    send_frame(14, 9, 1, 0, 0, 0, 0, 0);
    wait_frames();
    readback();
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
